fir_mc: RTL and testbench

- Parametrised successor to the team's 16-tap serial FIR.
- Time-multiplexed single-MAC FIR serving NCH independent channels; each channel has its own delay line, and all channels share one coefficient set.
- Coefficients are loaded at run time through a write port. Valid/ready handshakes on input and output; convergent widths; round-half-up; optional saturation.
- Sits between sample source (ADC front-end / decimator) and downstream DSP.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_round_sat.sv | 31 +++
 rtl/fir_mc.sv | 112 +++++++++++
 tb/tb_fir_mc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, width helpers and rounding constant for fir_mc
package fir_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DONE, OUT} state_t;

    localparam int MAX_ACC_W = 128;

    function automatic int ch_w(input int nch);
        return nch > 1 ? $clog2(nch) : 1;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] round_bias(input int frac);
        return MAX_ACC_W'(1) << (frac - 1);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up rescale of the accumulator, clamped when FIR_SAT_EN is defined, wrapped otherwise
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W  = 36,
    parameter int DATA_W = 16,
    parameter int FRAC   = 15
)(
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] res
);

    localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(round_bias(FRAC));

    logic signed [ACC_W-1:0] r;

    assign r = (acc + BIAS) >>> FRAC;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    assign res = r > MAXV ? MAXV[DATA_W-1:0] : r < MINV ? MINV[DATA_W-1:0] : r[DATA_W-1:0];
`else
    logic unused_hi;

    assign unused_hi = ^r[ACC_W-1:DATA_W];
    assign res = r[DATA_W-1:0];
`endif

endmodule

// File: rtl/fir_mc.sv
// fir_mc: multichannel single-MAC FIR with run-time coefficients; saturation enabled by FIR_SAT_EN
module fir_mc
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int NCH    = 2,
    parameter int FRAC   = 15,
    localparam int CH_W  = ch_w(NCH),
    localparam int K_W   = $clog2(TAPS)
)(
    input  logic                     ck,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [K_W-1:0]           coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata
);

    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [CH_W:0]  NCH_L = (CH_W+1)'(NCH);
    localparam logic [K_W-1:0] KMAX  = K_W'(TAPS - 1);

    state_t state, nxt;

    logic signed [DATA_W-1:0] dl [NCH][TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] smp;
    logic [K_W-1:0]           k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] rs;
    logic                     in_range;

    assign in_range = {1'b0, in_ch} < NCH_L;
    assign prod     = dl[ch][k] * coef[k];

    fir_round_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .FRAC(FRAC)) u_rs (
        .acc (acc),
        .res (rs)
    );

    // state register
    always_ff @(posedge ck) begin
        state <= rst ? IDLE : nxt;
    end

    // next-state and handshake outputs; out-of-range channels fall straight back to IDLE
    always_comb begin
        nxt       = state;
        in_ready  = state == IDLE;
        out_valid = state == OUT;
        unique case (state)
            IDLE:    nxt = in_valid && in_range ? LOAD : IDLE;
            LOAD:    nxt = MAC;
            MAC:     nxt = k == KMAX ? DONE : MAC;
            DONE:    nxt = OUT;
            OUT:     nxt = out_ready ? IDLE : OUT;
            default: nxt = IDLE;
        endcase
    end

    // datapath: coefficient writes and sample capture in IDLE, shift in LOAD, accumulate in MAC, result in DONE
    always_ff @(posedge ck) begin
        if (rst) begin
            k        <= '0;
            acc      <= '0;
            ch       <= '0;
            smp      <= '0;
            out_data <= '0;
            out_ch   <= '0;
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < TAPS; i++)
                    dl[c][i] <= '0;
            for (int i = 0; i < TAPS; i++)
                coef[i] <= '0;
        end else begin
            if (state == IDLE && coef_we)
                coef[coef_addr] <= coef_wdata;
            if (state == IDLE && in_valid && in_range) begin
                ch  <= in_ch;
                smp <= in_data;
            end
            if (state == LOAD) begin
                dl[ch][0] <= smp;
                for (int i = 1; i < TAPS; i++)
                    dl[ch][i] <= dl[ch][i-1];
                acc <= '0;
                k   <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                k   <= k + 1'b1;
            end
            if (state == DONE) begin
                out_data <= rs;
                out_ch   <= ch;
            end
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// tb_fir_mc: scoreboard bench for fir_mc; expected saturation results follow FIR_SAT_EN
module tb_fir_mc;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 16;
    localparam int NCH    = 2;
    localparam int FRAC   = 15;

`ifdef FIR_SAT_EN
    localparam int SAT_POS = 32767;
    localparam int SAT_NEG = -32768;
`else
    localparam int SAT_POS = -32;
    localparam int SAT_NEG = 16;
`endif

    logic ck = 0;
    logic rst = 1;
    logic signed [DATA_W-1:0] in_data = '0;
    logic [0:0] in_ch = '0;
    logic in_valid = 0;
    logic in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [0:0] out_ch;
    logic out_valid;
    logic out_ready = 1;
    logic coef_we = 0;
    logic [3:0] coef_addr = '0;
    logic signed [COEF_W-1:0] coef_wdata = '0;

    typedef struct {
        int ch;
        int d;
        bit chk;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int tests = 0;
    int fails = 0;

    fir_mc #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .NCH(NCH), .FRAC(FRAC)) dut (
        .ck         (ck),
        .rst        (rst),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pop and compare each output transfer
    always @(negedge ck) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got ch %0d data %0d expected no output", out_ch, out_data);
            end else begin
                m_e = q.pop_front();
                chk("out_ch", int'(out_ch), m_e.ch);
                if (m_e.chk)
                    chk("out_data", int'(out_data), m_e.d);
            end
        end
    end

    task automatic send(input int c, input int d, input int e, input bit check_d, input bit push);
        int n = 0;
        @(negedge ck);
        in_ch    = 1'(c);
        in_data  = 16'(d);
        in_valid = 1;
        while (!in_ready && n < 200) begin
            @(negedge ck);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else if (push) begin
            q.push_back('{c, e, check_d});
        end
        @(posedge ck);
        #1 in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge ck);
        while (!in_ready && n < 200) begin
            @(negedge ck);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic wcoef_raw(input int a, input int v);
        coef_we    = 1;
        coef_addr  = 4'(a);
        coef_wdata = 16'(v);
        @(posedge ck);
        #1 coef_we = 0;
    endtask

    task automatic wcoef(input int a, input int v);
        wait_idle();
        wcoef_raw(a, v);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge ck);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending outputs expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1;
        @(posedge ck);
        #1 rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        rst = 1;
        repeat (2) @(posedge ck);
        @(negedge ck);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        rst = 0;

        // impulse response
        for (int i = 0; i < TAPS; i++)
            wcoef(i, 1024 * (i + 1));
        send(0, 32767, 1024, 1, 1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge ck);
            #1;
            lat++;
        end
        chk("latency_edges", lat, TAPS + 3);
        for (int i = 1; i <= TAPS; i++)
            send(0, 0, i == TAPS ? 0 : 1024 * (i + 1), 1, 1);
        drain();

        // channel isolation: ch1 zeros interleaved with a ch0 impulse
        for (int i = 0; i <= TAPS; i++) begin
            send(0, i == 0 ? 32767 : 0, i == TAPS ? 0 : 1024 * (i + 1), 1, 1);
            send(1, 0, 0, 1, 1);
        end
        drain();

        // rounding with a single 0.5 tap
        wcoef(0, 16384);
        for (int i = 1; i < TAPS; i++)
            wcoef(i, 0);
        send(0, 3, 2, 1, 1);
        send(0, -3, -1, 1, 1);
        send(0, 1, 1, 1, 1);
        drain();

        // saturation / wrap with full-scale coefficients
        do_reset();
        for (int i = 0; i < TAPS; i++)
            wcoef(i, 32767);
        for (int i = 0; i < TAPS; i++)
            send(0, 32767, SAT_POS, i == TAPS - 1, 1);
        for (int i = 0; i < TAPS; i++)
            send(0, -32768, SAT_NEG, i == TAPS - 1, 1);
        drain();

        // backpressure in OUT
        do_reset();
        wcoef(0, 16384);
        out_ready = 0;
        send(0, 200, 100, 1, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge ck);
            n++;
        end
        chk("bp_valid_rise", int'(out_valid), 1);
        repeat (5) begin
            @(negedge ck);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_data", int'(out_data), 100);
            chk("bp_out_ch", int'(out_ch), 0);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge ck);
        #1 out_ready = 1;
        drain();

        // coefficient write during MAC is ignored
        send(0, 400, 200, 1, 1);
        repeat (3) @(negedge ck);
        wcoef_raw(0, 32767);
        send(0, 600, 300, 1, 1);
        drain();

        // reset in the middle of MAC discards the result and clears state
        wcoef(1, 16384);
        send(0, 800, 0, 0, 0);
        repeat (8) @(posedge ck);
        #1 rst = 1;
        @(posedge ck);
        #1 rst = 0;
        @(negedge ck);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        wcoef(0, 16384);
        send(0, 1000, 500, 1, 1);
        drain();
        repeat (5) @(negedge ck);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
